pa_result_wb: RTL and testbench
===============================

Name: pa_result_wb

Overview:
- Downstream writeback stage for the PA (processing-array) controller.
- Consumes the 16 per-tile accumulator results the controller offers through its dst_wr_rdy/dst_wr_acq handshake and result_addr index.
- Requantizes each result to int8 (multiply, rounding shift, offset, clamp) in a 3-stage pipeline.
- Writes each int8 result to destination RAM at base + tile*16 + index, with backpressure from the RAM side.

Parameters:
- ADDR_W, 16, destination RAM address width.
- TOTAL_W, 32, width of the output-count register.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and enters RUN.
- total_outputs  in  TOTAL_W  number of results to write in this job; sampled on start.
- dst_base  in  ADDR_W  destination base address; sampled on start.
- out_mult  in  32  signed requant multiplier; sampled on start.
- out_shift  in  5  right shift 0..31; sampled on start.
- out_offset  in  32  signed output offset; sampled on start.
- act_min  in  8  signed clamp low; sampled on start.
- act_max  in  8  signed clamp high; sampled on start.
- dst_wr_rdy  in  1  controller offers a result.
- result_addr  in  4  index 0..15 of the offered result within its tile.
- acc_data  in  32  signed accumulator value for result_addr.
- dst_wr_acq  out  1  this block accepts the offered result.
- mem_wr_en  out  1  destination RAM write strobe.
- mem_wr_addr  out  ADDR_W  destination RAM address.
- mem_wr_data  out  8  int8 result.
- mem_rdy  in  1  RAM accepts the write this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: FSM=IDLE. dst_wr_acq=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0. Pipeline valids, tile counter and write counter all clear.
- Reset mid-job aborts immediately: no done pulse, in-flight data discarded.

FSM IDLE -> RUN -> DONE -> IDLE:
- IDLE: start=1 latches all config and clears tile_cnt and wr_cnt. Goes to DONE if total_outputs==0, else RUN.
- RUN: busy=1. Leaves to DONE on the cycle a write fires (mem_wr_en & mem_rdy) with wr_cnt==total_outputs-1.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.

Handshake:
- Accept = dst_wr_rdy & dst_wr_acq.
- dst_wr_acq = (state==RUN) & !stall & (accepted_cnt < total_outputs).
- stall = s3_valid & !mem_rdy.
- When stall=1, all pipeline stages hold.

Pipeline (advances when !stall):
- S1: register acc_data and addr = dst_base + {tile_cnt,4'b0} + result_addr, truncated to ADDR_W.
- Accepting result_addr==15 increments tile_cnt.
- S2: prod = acc * out_mult, signed 64-bit.
- S3: rnd = (out_shift==0) ? 0 : 1<<(out_shift-1).
- S3: v = ((prod + rnd) >>> out_shift), truncated to signed 32, + out_offset with 32-bit wrap.
- S3: clamp to [act_min, act_max], giving an 8-bit result.
- Output: mem_wr_en = s3_valid; mem_wr_data / mem_wr_addr from S3.
- Outputs stay stable while mem_wr_en & !mem_rdy.
- Latency: accept in cycle N -> mem_wr_en in cycle N+3 if no stall. Throughput is 1 result/cycle.
- wr_cnt increments on each fired write.

Boundary conditions:
- act_min > act_max: result = act_max, since the low clamp is applied first and the high clamp last.
- An offer while the pipeline is stalled is held by the controller (its rdy stays up). There is no loss and no duplication.
- Accept and fire in the same cycle is legal.
- After total_outputs accepts, dst_wr_acq stays 0 for the rest of the job.
- ADDR_W address overflow wraps silently.

Test Plan:
- Mult 0x4000_0000, shift 30, offset 0, clamp [-128,127]; 16 results acc=0..15, base 0x100 -> mem writes addr 0x100..0x10F, data = round(acc*2^30/2^30) = acc; done after the 16th write; acq high 1 cycle after start, first mem_wr_en 3 cycles after first accept.
- Rounding/offset: acc=5, mult=1, shift=1, offset=-3 -> prod 5, (5+1)>>>1=3, 3-3=0 -> data 0x00; acc=-5 -> (-5+1)>>>1=-2, -5 -> 0xFB.
- Saturation: acc=1000, mult=1, shift 0, offset 0, clamp [-128,127] -> 0x7F; acc=-1000 -> 0x80; clamp [0,6] with acc=9 -> 0x06.
- Backpressure: 32 results, mem_rdy low for 5 cycles at write 3 -> mem_wr_en/addr/data held stable 5 cycles, dst_wr_acq low during stall; tile 2 addresses base+16..31; exactly 32 writes, no gaps or duplicates.
- total_outputs=0 -> done pulses one cycle after start, no writes, dst_wr_acq never high; start pulse during RUN ignored.
- Assert rst for 1 cycle while 3 results are in flight -> all outputs 0 immediately, no done; new start runs cleanly from tile 0.

Source files
------------

// File: rtl/pa_result_wb.sv
// Writeback stage for the PA controller: accepts per-tile accumulator results,
// requantizes them to int8 in a 3-stage pipeline and writes them to destination RAM.
module pa_result_wb #(
  parameter int ADDR_W  = 16,
  parameter int TOTAL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TOTAL_W-1:0] total_outputs,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [31:0]        out_mult,
  input  logic [4:0]         out_shift,
  input  logic [31:0]        out_offset,
  input  logic [7:0]         act_min,
  input  logic [7:0]         act_max,
  input  logic               dst_wr_rdy,
  input  logic [3:0]         result_addr,
  input  logic [31:0]        acc_data,
  output logic               dst_wr_acq,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [7:0]         mem_wr_data,
  input  logic               mem_rdy,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [TOTAL_W-1:0]       total_q, total_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic signed [31:0]       mult_q, mult_d;
  logic [4:0]               shift_q, shift_d;
  logic signed [31:0]       offset_q, offset_d;
  logic signed [7:0]        min_q, min_d;
  logic signed [7:0]        max_q, max_d;

  logic [ADDR_W-5:0]        tile_cnt_q, tile_cnt_d;
  logic [TOTAL_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic [TOTAL_W-1:0]       wr_cnt_q, wr_cnt_d;

  logic                     s1_valid_q, s1_valid_d;
  logic signed [31:0]       s1_acc_q, s1_acc_d;
  logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [63:0]       s2_prod_q, s2_prod_d;
  logic [ADDR_W-1:0]        s2_addr_q, s2_addr_d;
  logic                     s3_valid_q, s3_valid_d;
  logic [7:0]               s3_data_q, s3_data_d;
  logic [ADDR_W-1:0]        s3_addr_q, s3_addr_d;

  logic                     stall;
  logic                     fire;
  logic                     accept;
  logic signed [63:0]       rnd;
  logic signed [31:0]       v;
  logic signed [31:0]       min_ext;
  logic signed [31:0]       max_ext;

  assign stall      = s3_valid_q & ~mem_rdy;
  assign fire       = s3_valid_q & mem_rdy;
  assign dst_wr_acq = (state_q == RUN) & ~stall & (acc_cnt_q < total_q);
  assign accept     = dst_wr_rdy & dst_wr_acq;

  assign mem_wr_en   = s3_valid_q;
  assign mem_wr_addr = s3_addr_q;
  assign mem_wr_data = s3_data_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

  // Requantization of the S2 product: round-half-up shift, offset, then clamp.
  always_comb begin
    rnd     = (shift_q == 5'd0) ? 64'sd0 : (64'sd1 <<< (shift_q - 5'd1));
    v       = 32'((s2_prod_q + rnd) >>> shift_q) + offset_q;
    min_ext = min_q;
    max_ext = max_q;
    if (v < min_ext) begin
      // Low clamp first, high clamp last: an inverted range yields act_max.
      s3_data_d = (min_ext > max_ext) ? max_q : min_q;
    end else if (v > max_ext) begin
      s3_data_d = max_q;
    end else begin
      s3_data_d = v[7:0];
    end
    if (stall) begin
      s3_data_d = s3_data_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    base_d     = base_q;
    mult_d     = mult_q;
    shift_d    = shift_q;
    offset_d   = offset_q;
    min_d      = min_q;
    max_d      = max_q;
    tile_cnt_d = tile_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          total_d    = total_outputs;
          base_d     = dst_base;
          mult_d     = out_mult;
          shift_d    = out_shift;
          offset_d   = out_offset;
          min_d      = act_min;
          max_d      = act_max;
          tile_cnt_d = '0;
          acc_cnt_d  = '0;
          wr_cnt_d   = '0;
          state_d    = (total_outputs == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + TOTAL_W'(1);
          if (result_addr == 4'hF) begin
            tile_cnt_d = tile_cnt_q + 1'b1;
          end
        end
        if (fire) begin
          wr_cnt_d = wr_cnt_q + TOTAL_W'(1);
          if (wr_cnt_q == total_q - TOTAL_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Whole pipeline freezes together while the RAM refuses the S3 write.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_acc_d   = s1_acc_q;
    s1_addr_d  = s1_addr_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_addr_d  = s2_addr_q;
    s3_valid_d = s3_valid_q;
    s3_addr_d  = s3_addr_q;
    if (!stall) begin
      s1_valid_d = accept;
      s1_acc_d   = acc_data;
      s1_addr_d  = base_q + {tile_cnt_q, 4'b0000} + ADDR_W'(result_addr);
      s2_valid_d = s1_valid_q;
      s2_prod_d  = s1_acc_q * mult_q;
      s2_addr_d  = s1_addr_q;
      s3_valid_d = s2_valid_q;
      s3_addr_d  = s2_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      total_q    <= '0;
      base_q     <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      offset_q   <= '0;
      min_q      <= '0;
      max_q      <= '0;
      tile_cnt_q <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_acc_q   <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_addr_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      base_q     <= base_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      offset_q   <= offset_d;
      min_q      <= min_d;
      max_q      <= max_d;
      tile_cnt_q <= tile_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_acc_q   <= s1_acc_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_addr_q  <= s2_addr_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_addr_q  <= s3_addr_d;
    end
  end

endmodule

// File: tb/tb_pa_result_wb.sv
// Scoreboard bench for pa_result_wb: expected writes are queued at accept time
// and compared in order as the RAM accepts them.
module tb_pa_result_wb;
  localparam int ADDR_W  = 16;
  localparam int TOTAL_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [TOTAL_W-1:0] total_outputs;
  logic [ADDR_W-1:0]  dst_base;
  logic [31:0]        out_mult;
  logic [4:0]         out_shift;
  logic [31:0]        out_offset;
  logic [7:0]         act_min;
  logic [7:0]         act_max;
  logic               dst_wr_rdy;
  logic [3:0]         result_addr;
  logic [31:0]        acc_data;
  logic               dst_wr_acq;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [7:0]         mem_wr_data;
  logic               mem_rdy;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  pa_result_wb #(.ADDR_W(ADDR_W), .TOTAL_W(TOTAL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .total_outputs(total_outputs),
    .dst_base(dst_base), .out_mult(out_mult), .out_shift(out_shift),
    .out_offset(out_offset), .act_min(act_min), .act_max(act_max),
    .dst_wr_rdy(dst_wr_rdy), .result_addr(result_addr), .acc_data(acc_data),
    .dst_wr_acq(dst_wr_acq), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rdy(mem_rdy), .busy(busy), .done(done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] sb_q[$];
  int          acc_tbl[64];
  logic [7:0]  exp_tbl[64];
  bit          use_tbl;
  int          cfg_mult, cfg_shift, cfg_offset, cfg_min, cfg_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] requant(input int acc);
    longint p;
    int     r;
    p = longint'(acc) * longint'(cfg_mult);
    if (cfg_shift > 0) p = p + (longint'(1) << (cfg_shift - 1));
    p = p >>> cfg_shift;
    r = int'(p) + cfg_offset;
    if (r < cfg_min) r = cfg_min;
    if (r > cfg_max) r = cfg_max;
    return 8'(r);
  endfunction

  task automatic run_job(input int n, input int base, input int stall_at,
                         input int restart_at, input int abort_after, input bit check_lat);
    int idx = 0, writes = 0, stall_cnt = 0, done_cnt = 0;
    int first_acc = -1, first_wr = -1, done_cyc = -1, last_fire = -1;
    bit stall_used = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0] h_data, exp_d;
    logic [23:0] e;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      start         = (cyc == 0) || (cyc == restart_at);
      total_outputs = (cyc == restart_at) ? '0 : TOTAL_W'(n);
      dst_base      = (cyc == restart_at) ? 16'h7777 : 16'(base);
      out_mult      = cfg_mult;
      out_shift     = 5'(cfg_shift);
      out_offset    = cfg_offset;
      act_min       = 8'(cfg_min);
      act_max       = 8'(cfg_max);
      if (stall_at >= 0 && !stall_used && mem_wr_en && writes == stall_at) begin
        stall_cnt  = 5;
        stall_used = 1;
        h_addr     = mem_wr_addr;
        h_data     = mem_wr_data;
      end
      mem_rdy     = (stall_cnt == 0);
      dst_wr_rdy  = (idx < n) && !(abort_after > 0 && idx >= abort_after);
      result_addr = 4'(idx % 16);
      acc_data    = acc_tbl[idx % 64];
      @(negedge clk);
      if (cyc == 1 && check_lat) check("acq_after_start", {31'b0, dst_wr_acq}, 1);
      if (n == 0) check("acq_zero_job", {31'b0, dst_wr_acq}, 0);
      if (stall_cnt > 0) begin
        check("stall_en", {31'b0, mem_wr_en}, 1);
        check("stall_addr", 32'(mem_wr_addr), 32'(h_addr));
        check("stall_data", 32'(mem_wr_data), 32'(h_data));
        check("stall_acq", {31'b0, dst_wr_acq}, 0);
        stall_cnt--;
      end
      if (abort_after > 0 && idx == abort_after && mem_wr_en) begin
        rst = 1'b1; #1;
        check("abort_wr_en", {31'b0, mem_wr_en}, 0);
        check("abort_addr", 32'(mem_wr_addr), 0);
        check("abort_data", 32'(mem_wr_data), 0);
        check("abort_acq", {31'b0, dst_wr_acq}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; dst_wr_rdy = 1'b0; mem_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", {31'b0, done}, 0);
          check("abort_no_wr", {31'b0, mem_wr_en}, 0);
        end
        sb_q.delete();
        return;
      end
      if (dst_wr_rdy && dst_wr_acq) begin
        exp_d = use_tbl ? exp_tbl[idx] : requant(acc_tbl[idx % 64]);
        sb_q.push_back({16'(base + idx), exp_d});
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (mem_wr_en && first_wr < 0) first_wr = cyc;
      if (mem_wr_en && mem_rdy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(mem_wr_addr), 32'(e[23:8]));
          check("wr_data", 32'(mem_wr_data), 32'(e[7:0]));
        end
        writes++;
        last_fire = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0; dst_wr_rdy = 1'b0; mem_rdy = 1'b1;
    check("write_count", writes, n);
    check("done_count", done_cnt, 1);
    check("sb_left", sb_q.size(), 0);
    check("busy_after", {31'b0, busy}, 0);
    if (n == 0) check("done_zero_timing", done_cyc, 1);
    else        check("done_timing", done_cyc, last_fire + 1);
    if (check_lat && n > 0) check("first_wr_latency", first_wr - first_acc, 3);
    $display("job n=%0d base=0x%0h: %0d writes, done at cycle %0d", n, base, writes, done_cyc);
    sb_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; total_outputs = '0; dst_base = '0; out_mult = '0;
    out_shift = '0; out_offset = '0; act_min = '0; act_max = '0; dst_wr_rdy = 1'b0;
    result_addr = '0; acc_data = '0; mem_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acq", {31'b0, dst_wr_acq}, 0);
    check("rst_wr_en", {31'b0, mem_wr_en}, 0);
    check("rst_addr", 32'(mem_wr_addr), 0);
    check("rst_data", 32'(mem_wr_data), 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst = 1'b0;

    // Unity requant: data equals acc, base 0x100
    cfg_mult = 32'h4000_0000; cfg_shift = 30; cfg_offset = 0; cfg_min = -128; cfg_max = 127;
    use_tbl = 1;
    for (int i = 0; i < 16; i++) begin acc_tbl[i] = i; exp_tbl[i] = 8'(i); end
    run_job(16, 'h100, -1, -1, 0, 1);

    // Rounding and offset
    cfg_mult = 1; cfg_shift = 1; cfg_offset = -3;
    acc_tbl[0] = 5;  exp_tbl[0] = 8'h00;
    acc_tbl[1] = -5; exp_tbl[1] = 8'hFB;
    run_job(2, 'h40, -1, -1, 0, 1);

    // Saturation both ways
    cfg_shift = 0; cfg_offset = 0;
    acc_tbl[0] = 1000;  exp_tbl[0] = 8'h7F;
    acc_tbl[1] = -1000; exp_tbl[1] = 8'h80;
    run_job(2, 'h50, -1, -1, 0, 0);

    // Narrow clamp [0,6]
    cfg_min = 0; cfg_max = 6;
    acc_tbl[0] = 9; exp_tbl[0] = 8'h06;
    run_job(1, 'h60, -1, -1, 0, 0);

    // Inverted clamp range resolves to act_max
    cfg_min = 10; cfg_max = -10;
    acc_tbl[0] = 0;  exp_tbl[0] = 8'hF6;
    acc_tbl[1] = 50; exp_tbl[1] = 8'hF6;
    run_job(2, 'h70, -1, -1, 0, 0);

    // 32 results over two tiles, 5-cycle backpressure at write 3, stray start mid-run
    use_tbl = 0;
    cfg_mult = int'($urandom_range(1, 300)); cfg_shift = 12; cfg_offset = 5;
    cfg_min = -100; cfg_max = 100;
    for (int i = 0; i < 64; i++) acc_tbl[i] = int'($urandom_range(0, 4000)) - 2000;
    run_job(32, 'h200, 3, 6, 0, 1);

    // Address wrap past the top of the RAM
    cfg_mult = 3; cfg_shift = 0; cfg_offset = -1; cfg_min = -128; cfg_max = 127;
    for (int i = 0; i < 16; i++) acc_tbl[i] = i - 8;
    run_job(16, 'hFFF8, -1, -1, 0, 0);

    // Empty job
    run_job(0, 'h10, -1, -1, 0, 0);

    // Reset with three results in flight, then a clean job from tile 0
    run_job(16, 'h400, -1, -1, 3, 0);
    for (int i = 0; i < 16; i++) acc_tbl[i] = 20 * i - 150;
    run_job(16, 'h300, -1, -1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
